// File: rtl/blram_dp.sv
// blram_dp: dual-port synchronous block RAM (port A = processor, port B = loader/debug).
// Optional post-reset clear sweep enabled by defining BLRAM_DP_CLEAR_EN; busy is high while it runs.
// Read data is registered (1-cycle latency, read-old-data on same-address write).
// On a same-address double write, port A wins.

module blram_dp #(
   parameter int unsigned SIZE  = 8,
   parameter int unsigned DEPTH = 2**SIZE,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [SIZE-1:0]  addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   input  logic             we_b,
   input  logic [SIZE-1:0]  addr_b,
   input  logic [WIDTH-1:0] din_b,
   output logic [WIDTH-1:0] dout_b,
   output logic             busy
);

   localparam logic [SIZE:0] DEPTH_X = (SIZE+1)'(DEPTH);

   logic [WIDTH-1:0] mem [0:DEPTH-1];

   logic inA;
   logic inB;
   logic wrA;
   logic wrB;
   logic clearing;

   // Address range checks; out-of-range accesses read 0 and never write.
   assign inA = {1'b0, addr}   < DEPTH_X;
   assign inB = {1'b0, addr_b} < DEPTH_X;

   // Port writes are suppressed while sweeping; port B loses a same-address write race.
   assign wrA = we   & inA & ~clearing;
   assign wrB = we_b & inB & ~clearing & ~(wrA & (addr_b == addr));

`ifdef BLRAM_DP_CLEAR_EN
   localparam logic [SIZE:0] LAST = (SIZE+1)'(DEPTH - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t        state;
   state_t        stateNext;
   logic [SIZE:0] clr_ptr;
   logic [SIZE:0] clrPtrNext;

   // State and sweep pointer registers; reset restarts the sweep from word 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_ptr <= '0;
      end else begin
         state   <= stateNext;
         clr_ptr <= clrPtrNext;
      end
   end

   // Sweep sequencing: leave CLEAR on the edge that zeroes the last word.
   always_comb begin
      stateNext  = state;
      clrPtrNext = clr_ptr;
      case (state)
         CLEAR: begin
            clrPtrNext = clr_ptr + (SIZE+1)'(1);
            if (clr_ptr == LAST) begin
               stateNext = READY;
            end
         end
         READY: begin
            stateNext = READY;
         end
         default: begin
            stateNext = CLEAR;
         end
      endcase
   end

   assign clearing = (state == CLEAR);
   assign busy     = clearing;

   // Array update: sweep write during CLEAR, otherwise up to two port writes.
   always_ff @(posedge clk) begin
      if (clearing) begin
         mem[clr_ptr[SIZE-1:0]] <= '0;
      end
      if (wrA) begin
         mem[addr] <= din;
      end
      if (wrB) begin
         mem[addr_b] <= din_b;
      end
   end
`else
   assign clearing = 1'b0;
   assign busy     = 1'b0;

   // Array update: up to two port writes per edge; contents survive reset.
   always_ff @(posedge clk) begin
      if (wrA) begin
         mem[addr] <= din;
      end
      if (wrB) begin
         mem[addr_b] <= din_b;
      end
   end
`endif

   // Registered read data; zero in reset, during the sweep and for out-of-range addresses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout   <= '0;
         dout_b <= '0;
      end else begin
         dout   <= (inA && !clearing) ? mem[addr]   : '0;
         dout_b <= (inB && !clearing) ? mem[addr_b] : '0;
      end
   end

endmodule

// File: tb/tb_blram_dp.sv
// tb_blram_dp: scoreboard bench for blram_dp (default-size instance plus a DEPTH=200 instance).
// Stimulus pushes expected values tagged with a cycle; a negedge monitor pops and compares.

module tb_blram_dp;

   logic        clk = 1'b0;
   logic        rst;

   logic        we, weB, busy;
   logic [7:0]  addr, addrB;
   logic [15:0] din, dinB, dout, doutB;

   logic        we2, weB2, busy2;
   logic [7:0]  addr2, addrB2;
   logic [15:0] din2, dinB2, dout2, doutB2;

   int unsigned cyc = 0;
   int          passCnt = 0;
   int          totalCnt = 0;

   typedef struct {
      int unsigned cyc;
      int          sel;
      int          addr;
      logic [15:0] exp;
      string       name;
   } chk_t;

   chk_t        sb[$];
   chk_t        mc;
   logic [15:0] mAct;

   localparam int S_DOUT = 0, S_DOUTB = 1, S_BUSY = 2, S_MEM = 3,
                  S_DOUT2 = 4, S_DOUTB2 = 5, S_BUSY2 = 6;

   blram_dp uDut (
      .clk(clk), .rst(rst),
      .we(we), .addr(addr), .din(din), .dout(dout),
      .we_b(weB), .addr_b(addrB), .din_b(dinB), .dout_b(doutB),
      .busy(busy)
   );

   blram_dp #(.SIZE(8), .DEPTH(200), .WIDTH(16)) uDut200 (
      .clk(clk), .rst(rst),
      .we(we2), .addr(addr2), .din(din2), .dout(dout2),
      .we_b(weB2), .addr_b(addrB2), .din_b(dinB2), .dout_b(doutB2),
      .busy(busy2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] sample(input int sel, input int a);
      case (sel)
         S_DOUT:   return dout;
         S_DOUTB:  return doutB;
         S_BUSY:   return {15'b0, busy};
         S_MEM:    return uDut.mem[a];
         S_DOUT2:  return dout2;
         S_DOUTB2: return doutB2;
         S_BUSY2:  return {15'b0, busy2};
         default:  return 16'hxxxx;
      endcase
   endfunction

   // Monitor: compare every entry whose cycle has been reached.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mc   = sb.pop_front();
         mAct = sample(mc.sel, mc.addr);
         totalCnt++;
         if (mAct === mc.exp) passCnt++;
         else $display("FAIL %s: got %h expected %h (cycle %0d)", mc.name, mAct, mc.exp, cyc);
      end
   end

   task automatic expectAt(input int sel, input int a, input logic [15:0] exp,
                           input int unsigned dly, input string name);
      chk_t c;
      c.cyc  = cyc + dly;
      c.sel  = sel;
      c.addr = a;
      c.exp  = exp;
      c.name = name;
      sb.push_back(c);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; weB = 1'b0; we2 = 1'b0; weB2 = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      addr = '0; addrB = '0; din = '0; dinB = '0;
      addr2 = '0; addrB2 = '0; din2 = '0; dinB2 = '0;
      uDut.mem[14] = 16'h0005;
      uDut.mem[15] = 16'h0005;

      // Reset state
      step(2);
      expectAt(S_DOUT,   0, 16'h0000, 0, "rst_dout");
      expectAt(S_DOUTB,  0, 16'h0000, 0, "rst_dout_b");
      expectAt(S_DOUT2,  0, 16'h0000, 0, "rst_dout200");
`ifdef BLRAM_DP_CLEAR_EN
      expectAt(S_BUSY,   0, 16'h0001, 0, "rst_busy");
`else
      expectAt(S_BUSY,   0, 16'h0000, 0, "rst_busy");
`endif
      step(8);

`ifdef BLRAM_DP_CLEAR_EN
      // Clear sweep: busy for exactly 256 edges, write during sweep dropped
      we = 1'b1; addr = 8'd3; din = 16'h1234;
      rst = 1'b0;
      expectAt(S_BUSY,  0, 16'h0001, 1,   "busy_edge1");
      expectAt(S_DOUT,  0, 16'h0000, 5,   "dout_in_sweep");
      expectAt(S_BUSY,  0, 16'h0001, 255, "busy_edge255");
      expectAt(S_BUSY,  0, 16'h0000, 256, "busy_edge256");
      expectAt(S_BUSY2, 0, 16'h0001, 199, "busy200_edge199");
      expectAt(S_BUSY2, 0, 16'h0000, 200, "busy200_edge200");
      step(10);
      idle();
      step(246);
      expectAt(S_MEM, 14,  16'h0000, 0, "mem14_cleared");
      expectAt(S_MEM, 3,   16'h0000, 0, "mem3_dropped");
      expectAt(S_MEM, 0,   16'h0000, 0, "mem0_cleared");
      expectAt(S_MEM, 255, 16'h0000, 0, "mem255_cleared");
      addr = 8'd14;
      expectAt(S_DOUT, 0, 16'h0000, 1, "rd14_after_sweep");
      step(1);
`else
      // Preload survives reset, read ready on the first edge after release
      addr = 8'd15;
      rst = 1'b0;
      expectAt(S_DOUT, 0, 16'h0005, 1, "rd15_after_rst");
      expectAt(S_BUSY, 0, 16'h0000, 1, "busy_off");
      step(1);
`endif

      // Read-old-data across ports, then new data next edge
      we = 1'b1; addr = 8'd20; din = 16'h0C0C;
      step(1);
      din = 16'hBEEF; addrB = 8'd20;
      expectAt(S_DOUTB, 0, 16'h0C0C, 1, "b_reads_old");
      expectAt(S_DOUT,  0, 16'h0C0C, 1, "a_reads_old");
      step(1);
      we = 1'b0;
      expectAt(S_DOUTB, 0, 16'hBEEF, 1, "b_reads_new");
      step(1);

      // Write collision: port A wins, both read identical data
      we = 1'b1; addr = 8'd7; din = 16'hAAAA;
      weB = 1'b1; addrB = 8'd7; dinB = 16'h5555;
      step(1);
      idle();
      expectAt(S_MEM,   7, 16'hAAAA, 0, "mem7_collision");
      expectAt(S_DOUT,  0, 16'hAAAA, 1, "a_rd7");
      expectAt(S_DOUTB, 0, 16'hAAAA, 1, "b_rd7");
      step(1);

      // Port B write path
      weB = 1'b1; addrB = 8'd9; dinB = 16'h3C3C;
      step(1);
      weB = 1'b0; addr = 8'd9;
      expectAt(S_DOUT, 0, 16'h3C3C, 1, "a_rd9_bwrite");
      step(1);

      // Out of range on DEPTH=200 instance
      we2 = 1'b1; addr2 = 8'd199; din2 = 16'h0042;
      step(1);
      addr2 = 8'd210; din2 = 16'h00FF;
      step(1);
      we2 = 1'b0; addrB2 = 8'd199;
      expectAt(S_DOUT2,  0, 16'h0000, 1, "oor_rd210");
      expectAt(S_DOUTB2, 0, 16'h0042, 1, "rd199_b");
      step(1);
      addr2 = 8'd199; weB2 = 1'b1; addrB2 = 8'd255; dinB2 = 16'h1111;
      expectAt(S_DOUT2,  0, 16'h0042, 1, "rd199_a");
      expectAt(S_DOUTB2, 0, 16'h0000, 1, "oor_rd255_b");
      step(1);
      weB2 = 1'b0; addrB2 = 8'd200;
      expectAt(S_DOUTB2, 0, 16'h0000, 1, "oor_rd200_b");
      expectAt(S_DOUT2,  0, 16'h0042, 1, "rd199_intact");
      step(1);

      // Reset mid-operation: outputs clear asynchronously
      addr = 8'd7; addrB = 8'd7;
      expectAt(S_DOUT, 0, 16'hAAAA, 1, "pre_rst_rd7");
      step(1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      expectAt(S_DOUT,  0, 16'h0000, 0, "midrst_dout");
      expectAt(S_DOUTB, 0, 16'h0000, 0, "midrst_dout_b");
`ifdef BLRAM_DP_CLEAR_EN
      expectAt(S_BUSY,  0, 16'h0001, 0, "midrst_busy");
`else
      expectAt(S_BUSY,  0, 16'h0000, 0, "midrst_busy");
`endif
      step(3);
      rst = 1'b0;
`ifdef BLRAM_DP_CLEAR_EN
      step(256);
      expectAt(S_MEM,  7, 16'h0000, 0, "mem7_recleared");
      expectAt(S_DOUT, 0, 16'h0000, 1, "rd7_recleared");
`else
      expectAt(S_DOUT, 0, 16'hAAAA, 1, "rd7_survives_rst");
`endif
      step(1);

      // Drain scoreboard with a bounded wait
      step(2);
      for (int i = 0; i < 10 && sb.size() > 0; i++) step(1);
      if (sb.size() > 0) begin
         totalCnt++;
         $display("FAIL drain: %0d checks pending, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
